// File: rtl/draw_items.sv
// Overlays up to N_ITEMS grid-cell objects on the pixel stream, with attributes latched at each vsync rising edge.
// Optional blinking is compiled in with `define DRAW_ITEMS_BLINK_EN.
module draw_items #(
  parameter int N_ITEMS      = 4,
  parameter int X_W          = 7,
  parameter int Y_W          = 6,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [10:0]            hcount_in,
  input  logic [10:0]            vcount_in,
  input  logic                   hsync_in,
  input  logic                   hblnk_in,
  input  logic                   vsync_in,
  input  logic                   vblnk_in,
  input  logic [11:0]            rgb_in,
  input  logic [N_ITEMS*X_W-1:0] item_x,
  input  logic [N_ITEMS*Y_W-1:0] item_y,
  input  logic [N_ITEMS*12-1:0]  item_color,
  input  logic [N_ITEMS-1:0]     item_en,
  input  logic [N_ITEMS-1:0]     item_blink,
  input  logic [9:0]             grid_size,
  output logic [10:0]            hcount_out,
  output logic [10:0]            vcount_out,
  output logic                   hsync_out,
  output logic                   hblnk_out,
  output logic                   vsync_out,
  output logic                   vblnk_out,
  output logic [11:0]            rgb_out,
  output logic                   origins_valid
);

  localparam int ORIG_W = 17;
  localparam int KW     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [KW-1:0]       k;
  logic                vsync_q;
  logic                vs_rise;
  logic [X_W-1:0]      sx     [N_ITEMS];
  logic [Y_W-1:0]      sy     [N_ITEMS];
  logic [11:0]         scolor [N_ITEMS];
  logic [ORIG_W-1:0]   ox     [N_ITEMS];
  logic [ORIG_W-1:0]   oy     [N_ITEMS];
  logic [N_ITEMS-1:0]  sen;
  logic [N_ITEMS-1:0]  en_eff;
  logic [9:0]          sgrid;
  logic [X_W+9:0]      mul_x;
  logic [Y_W+9:0]      mul_y;

  assign vs_rise = vsync_in & ~vsync_q;

  // One shared multiplier pair, walked across the objects by index k.
  assign mul_x = (X_W+10)'(sx[k]) * (X_W+10)'(sgrid);
  assign mul_y = (Y_W+10)'(sy[k]) * (Y_W+10)'(sgrid);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      // NOTE: shadow and origin arrays are reset explicitly so a reset mid-CALC
      // can never expose a half-computed frame.
      vsync_q       <= 1'b0;
      state         <= IDLE;
      k             <= '0;
      origins_valid <= 1'b0;
      sgrid         <= '0;
      sen           <= '0;
      for (int i = 0; i < N_ITEMS; i++) begin
        sx[i]     <= '0;
        sy[i]     <= '0;
        scolor[i] <= '0;
        ox[i]     <= '0;
        oy[i]     <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      vsync_q <= vsync_in;
      if (vs_rise) begin
        sgrid         <= grid_size;
        sen           <= item_en;
        state         <= CALC;
        k             <= '0;
        origins_valid <= 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
          sx[i]     <= item_x[i*X_W +: X_W];
          sy[i]     <= item_y[i*Y_W +: Y_W];
          scolor[i] <= item_color[i*12 +: 12];
        end
      end else begin
        case (state)
          IDLE: ;
          CALC: begin
            ox[k] <= ORIG_W'(mul_x);
            oy[k] <= ORIG_W'(mul_y);
            if (k == KW'(N_ITEMS-1)) state <= DONE;
            else                     k     <= k + KW'(1);
          end
          DONE:    origins_valid <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef DRAW_ITEMS_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0]    frame_cnt;
  logic               phase;
  logic [N_ITEMS-1:0] sblink;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
      sblink    <= '0;
    end else if (vs_rise) begin
      sblink <= item_blink;
      if (frame_cnt == FC_W'(BLINK_FRAMES-1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  assign en_eff = sen & ~(sblink & {N_ITEMS{phase}});
`else
  logic unused_blink;
  assign unused_blink = ^item_blink;
  assign en_eff       = sen;
`endif

  // Hit test: all coordinates widened to the origin width so nothing wraps.
  logic [N_ITEMS-1:0] hit;
  logic [ORIG_W-1:0]  h_ext, v_ext, g_ext;

  assign h_ext = ORIG_W'(hcount_in);
  assign v_ext = ORIG_W'(vcount_in);
  assign g_ext = ORIG_W'(sgrid);

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    hit = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      hit[i] = en_eff[i] & origins_valid
             & (h_ext >= ox[i]) & (h_ext < ox[i] + g_ext)
             & (v_ext >= oy[i]) & (v_ext < oy[i] + g_ext);
    end
  end

  logic [10:0]        hcount_d, vcount_d;
  logic               hsync_d, hblnk_d, vsync_d, vblnk_d;
  logic [11:0]        rgb_d;
  logic [N_ITEMS-1:0] hit_d;
  logic [11:0]        rgb_sel;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_d <= '0;
      vcount_d <= '0;
      hsync_d  <= 1'b0;
      hblnk_d  <= 1'b0;
      vsync_d  <= 1'b0;
      vblnk_d  <= 1'b0;
      rgb_d    <= '0;
      hit_d    <= '0;
    end else begin
      hcount_d <= hcount_in;
      vcount_d <= vcount_in;
      hsync_d  <= hsync_in;
      hblnk_d  <= hblnk_in;
      vsync_d  <= vsync_in;
      vblnk_d  <= vblnk_in;
      rgb_d    <= rgb_in;
      hit_d    <= hit;
    end
  end

  // Scan from the highest index down so the lowest hitting index wins.
  always_comb begin
    rgb_sel = rgb_d;
    if (!(hblnk_d || vblnk_d)) begin
      for (int i = N_ITEMS-1; i >= 0; i--) begin
        if (hit_d[i]) rgb_sel = scolor[i];
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_d;
      vcount_out <= vcount_d;
      hsync_out  <= hsync_d;
      hblnk_out  <= hblnk_d;
      vsync_out  <= vsync_d;
      vblnk_out  <= vblnk_d;
      rgb_out    <= rgb_sel;
    end
  end

endmodule

// File: doc/draw_items.md
# draw_items

Draws up to `N_ITEMS` grid-cell objects (apples, bonuses, obstacles) over the incoming VGA pixel stream. Each object has its own position, colour, enable and blink flag. Object attributes are sampled once per frame at the vsync rising edge, so a frame never tears. Sits in the pixel pipeline after the background/snake draw stages; generalises the single-apple drawer to N objects with a frame-synchronous update, a pre-computed cell origin and optional blinking.

## Interface

Parameters:
- `N_ITEMS`, 4 — number of objects (1..16)
- `X_W`, 7 — width of each cell x coordinate
- `Y_W`, 6 — width of each cell y coordinate
- `BLINK_FRAMES`, 16 — frames per blink half-period (≥1)

Ports:
- `pclk` in 1 — pixel clock; the only clock
- `rst` in 1 — asynchronous, active-high reset
- `hcount_in`, `vcount_in` in 11 each — pixel counters
- `hsync_in`, `hblnk_in`, `vsync_in`, `vblnk_in` in 1 each — timing signals
- `rgb_in` in 12 — upstream colour
- `item_x` in `N_ITEMS*X_W` — cell x per object; object i occupies `[i*X_W +: X_W]`
- `item_y` in `N_ITEMS*Y_W` — cell y per object
- `item_color` in `N_ITEMS*12` — colour per object
- `item_en` in `N_ITEMS` — object visible
- `item_blink` in `N_ITEMS` — object blinks
- `grid_size` in 10 — cell edge in pixels
- `hcount_out`, `vcount_out` out 11; `hsync_out`, `hblnk_out`, `vsync_out`, `vblnk_out` out 1; `rgb_out` out 12 — delayed stream
- `origins_valid` out 1 — cell origins for the current frame are ready

## Operation

- **Vsync edge detect:** `vsync_in` is registered; `vs_rise = vsync_in & ~vsync_q`.
- **On `vs_rise`:**
  - All `item_*` inputs and `grid_size` are copied into shadow registers.
  - `origins_valid` clears.
  - The origin FSM enters CALC.
  - Input changes at any other time are ignored until the next `vs_rise`.
- **Origin FSM:** IDLE → CALC → DONE.
  - CALC uses one shared multiplier pair. Index k (0..N_ITEMS-1), one per cycle: `ox[k] = sx[k]*sgrid` and `oy[k] = sy[k]*sgrid`, stored in 17-bit origin registers.
  - After k = N_ITEMS-1: DONE, `origins_valid` = 1.
  - A `vs_rise` in CALC or DONE restarts at k = 0 with fresh shadows.
- **Hit test (per object i):**
  - `hit[i] = en_eff[i] & origins_valid & hcount ≥ ox[i] & hcount < ox[i]+sgrid & vcount ≥ oy[i] & vcount < oy[i]+sgrid`.
  - All compares are zero-extended to 17 bits; no truncation.
- **Priority:** the lowest index wins on overlap.
- **Colour select:**
  - During `hblnk` or `vblnk`, `rgb_out` = delayed `rgb_in`.
  - Otherwise the winning object's colour is output, or `rgb_in` if there is no hit.
- **`grid_size` = 0:** the empty interval never hits; the stream passes through.
- **`en_eff`:** equals the shadow `item_en`, masked by blink when `DRAW_ITEMS_BLINK_EN` is defined (see Configuration).

## Timing

- **Latency:** 2 `pclk` cycles, identical for every output.
  - Stage 1 registers the hit vector plus delayed timing signals and `rgb_in`.
  - Stage 2 registers the priority-selected colour and the timing signals.
- **Origin computation:** N_ITEMS+1 cycles after `vs_rise`. This is far shorter than the vsync pulse, so origins are ready before the first visible line.
- **Reset values:**
  - All outputs 0; `origins_valid` 0.
  - Shadows and origins 0; shadow `item_en` 0; FSM IDLE.
  - Frame counter 0; blink phase 0.
- **After reset:** no object is drawn until the first `vs_rise` plus N_ITEMS+1 cycles. Pixels in that window pass `rgb_in` through with 2-cycle latency.
- **Reset asserted mid-frame or mid-CALC:** immediate return to the reset state; no partial origins are used.

## Configuration

- **`DRAW_ITEMS_BLINK_EN` defined:**
  - A frame counter (`$clog2(BLINK_FRAMES)` bits) advances on each `vs_rise`.
  - At `BLINK_FRAMES-1` it wraps to 0 and toggles the blink phase.
  - While the phase is 1, objects with shadow `item_blink` = 1 are masked out of `en_eff`.
  - The phase changes only at `vs_rise`, so an object is never half-drawn.
- **Not defined:** the counter and phase logic are absent, `item_blink` is ignored, and `en_eff` = shadow `item_en`.

## Test plan

- **Single object:** grid_size=20, item0 x=3 y=2 colour 0xF00, en=1, others off, rgb_in=0x0F0. Expect:
  - rgb_out=0xF00 exactly for hcount 60..79 and vcount 40..59, 2 cycles after the input pixel.
  - 0x0F0 elsewhere.
- **Overlap priority:** items 1 and 3 both at (5,5), colours 0x00F and 0xFFF. Expect 0x00F inside the cell.
- **Frame sync:** change item0 x from 3 to 4 mid-frame. Expect:
  - The old position is drawn until the next vsync.
  - The new position (hcount 80..99) is drawn from the following frame on.
  - `origins_valid` is low for N_ITEMS+1 cycles after `vs_rise`.
- **Boundaries:** grid_size=0 gives pure pass-through. x=127, grid_size=16 gives origin 2032 with no overflow and no hit within hcount<1056. Blanking pixels always pass `rgb_in`.
- **Blink (macro on):** BLINK_FRAMES=2, item_blink=1. Expect the object visible for frames 0-1, hidden for 2-3, visible for 4-5. With the macro off, the object is always visible.
- **Reset:** assert `rst` mid-CALC and mid-line. Expect all outputs 0 immediately. After release, pass-through only until the next vsync completes CALC.
